// File: rtl/remapper_pkg.sv
// remapper_pkg: types and default sizes shared by the kernel assembler and
// the 12K remapper that sits downstream of it.
//   pixel_t     - one pixel, DATA_WIDTH bits
//   kernel_t    - IMAGE_KERNEL_12K pixels, element 0 first received
//   asm_state_t - assembler FSM state (IDLE, FILL)
package remapper_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int IMAGE_KERNEL_12K = 64;

  typedef logic [DATA_WIDTH-1:0]           pixel_t;
  typedef pixel_t [0:IMAGE_KERNEL_12K-1]   kernel_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } asm_state_t;

endpackage

// File: rtl/kernel_assembler_if.sv
// kernel_assembler_if: serial pixel stream in, parallel kernel out.
//   i_pixel_data/i_pixel_valid/i_sof   - pixel beat from upstream (no backpressure)
//   o_image_kernel                     - last completed kernel, element 0 first
//   o_kernel_is_ready                  - one-cycle pulse when the kernel updates
//   o_kernel_is_odd                    - kernel index parity within the frame
//   o_frame_done                       - pulse with ready for the frame's last kernel
//   o_sof_error                        - pulse when SOF lands mid-kernel
//   o_sof_err_count                    - only with KERNEL_ASM_ERR_CNT_EN defined
// Modports: master = upstream/consumer side, slave = the assembler.
interface kernel_assembler_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int IMAGE_KERNEL_12K = 64
);

  logic [DATA_WIDTH-1:0]                         i_pixel_data;
  logic                                          i_pixel_valid;
  logic                                          i_sof;
  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]   o_image_kernel;
  logic                                          o_kernel_is_ready;
  logic                                          o_kernel_is_odd;
  logic                                          o_frame_done;
  logic                                          o_sof_error;
`ifdef KERNEL_ASM_ERR_CNT_EN
  logic [15:0]                                   o_sof_err_count;
`endif

  modport master (
    output i_pixel_data, i_pixel_valid, i_sof,
    input  o_image_kernel, o_kernel_is_ready, o_kernel_is_odd,
           o_frame_done, o_sof_error
`ifdef KERNEL_ASM_ERR_CNT_EN
    , input o_sof_err_count
`endif
  );

  modport slave (
    input  i_pixel_data, i_pixel_valid, i_sof,
    output o_image_kernel, o_kernel_is_ready, o_kernel_is_odd,
           o_frame_done, o_sof_error
`ifdef KERNEL_ASM_ERR_CNT_EN
    , output o_sof_err_count
`endif
  );

endinterface

// File: rtl/kernel_assembler.sv
// kernel_assembler: collects a serial pixel stream into IMAGE_KERNEL_12K-pixel
// kernels and presents each completed kernel on a registered parallel bus.
// Ports:
//   i_clk      - clock, rising edge
//   i_aresetn  - asynchronous active-low reset
//   px         - kernel_assembler_if.slave (pixel stream in, kernel bus out)
// Optional: define KERNEL_ASM_ERR_CNT_EN to add a saturating 16-bit count of
// SOF errors on px.o_sof_err_count.
// Requires IMAGE_KERNEL_12K >= 2 and KERNELS_PER_FRAME >= 1.
module kernel_assembler #(
  parameter int DATA_WIDTH        = remapper_pkg::DATA_WIDTH,
  parameter int IMAGE_KERNEL_12K  = remapper_pkg::IMAGE_KERNEL_12K,
  parameter int KERNELS_PER_FRAME = 16
) (
  input logic               i_clk,
  input logic               i_aresetn,
  kernel_assembler_if.slave px
);
  import remapper_pkg::*;

  localparam int CW = $clog2(IMAGE_KERNEL_12K);
  localparam int KW = (KERNELS_PER_FRAME > 1) ? $clog2(KERNELS_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_PIX  = CW'(IMAGE_KERNEL_12K - 1);
  localparam logic [KW-1:0] LAST_KERN = KW'(KERNELS_PER_FRAME - 1);

  typedef logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] kern_vec_t;
  // Accumulation buffer only needs N-1 slots: the last pixel goes straight
  // from the input into the output register on the completing beat.
  typedef logic [0:IMAGE_KERNEL_12K-2][DATA_WIDTH-1:0] acc_vec_t;

  asm_state_t       state_q, state_d;
  logic [CW-1:0]    pix_q, pix_d;
  logic [KW-1:0]    kern_q, kern_d;
  acc_vec_t         acc_q;
  kern_vec_t        kernel_q, kernel_d;
  logic             odd_q, ready_q, done_q, err_q;

  logic             wr_en;
  logic             complete;
  logic             last_kern;
  logic             sof_err;

  // Next-state / control
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    kern_d    = kern_q;
    wr_en     = 1'b0;
    complete  = 1'b0;
    last_kern = 1'b0;
    sof_err   = 1'b0;
    if (px.i_pixel_valid) begin
      if (px.i_sof) begin
        // SOF wins over everything, including a completing beat: the
        // partial kernel is dropped and this beat starts kernel 0.
        sof_err = (state_q == FILL);
        wr_en   = 1'b1;
        pix_d   = CW'(1);
        kern_d  = '0;
        state_d = FILL;
      end else if (state_q == FILL) begin
        if (pix_q == LAST_PIX) begin
          complete = 1'b1;
          pix_d    = '0;
          if (kern_q == LAST_KERN) begin
            last_kern = 1'b1;
            kern_d    = '0;
            state_d   = IDLE;
          end else begin
            kern_d = kern_q + KW'(1);
          end
        end else begin
          wr_en = 1'b1;
          pix_d = pix_q + CW'(1);
        end
      end
    end
  end

  // The SOF beat writes slot 0; pix_q is the slot otherwise.
  logic [CW-1:0] wr_idx;
  assign wr_idx   = px.i_sof ? '0 : pix_q;
  assign kernel_d = {acc_q, px.i_pixel_data};

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      pix_q   <= '0;
      kern_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      kern_q  <= kern_d;
      if (wr_en) acc_q[wr_idx] <= px.i_pixel_data;
    end
  end

  // Output register: holds the last kernel until the next completion.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      kernel_q <= '0;
      odd_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= complete;
      done_q  <= last_kern;
      err_q   <= sof_err;
      if (complete) begin
        kernel_q <= kernel_d;
        odd_q    <= kern_q[0];
      end
    end
  end

  assign px.o_image_kernel    = kernel_q;
  assign px.o_kernel_is_ready = ready_q;
  assign px.o_kernel_is_odd   = odd_q;
  assign px.o_frame_done      = done_q;
  assign px.o_sof_error       = err_q;

`ifdef KERNEL_ASM_ERR_CNT_EN
  // Counts on the same edge that raises o_sof_error, so the count already
  // includes an error while its pulse is visible.
  logic [15:0] err_cnt_q;
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn)                           err_cnt_q <= '0;
    else if (sof_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign px.o_sof_err_count = err_cnt_q;
`endif

endmodule
